// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Time-multiplexes a 32-bit, 8-nibble word onto an 8-digit common-anode
//   seven-segment display. Each nibble is shown as a hex glyph, and the
//   cursor digit is marked with the decimal point. New words arrive through
//   a load/ack handshake and are committed only at frame boundaries, so a
//   scan never shows a mix of old and new digits.
//
// Parameters
//   SCAN_DIV      clk cycles per digit slot (>= 2)
//   BLINK_FRAMES  frames per cursor blink half-period (blink build only)
//
// Optional feature (compile-time macro CURSOR_BLINK_EN)
//   Defined  : the cursor digit blinks. During the off phase its slot drives
//              all anodes off, but dp_o stays asserted for that slot.
//   Undefined: the cursor digit is always lit and is marked by dp_o only.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   data_i   in   [31:0] nibble word; nibble k drives digit k
//   sel_i    in   [2:0]  cursor digit index, sampled live
//   load_i   in   request to load data_i
//   ack_o    out  one-cycle pulse when a loaded word is committed
//   frame_o  out  one-cycle pulse after each frame boundary (digit 7 -> 0)
//   an_o     out  [7:0] anode enables, active-low, one-hot-low
//   seg_o    out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp_o     out  decimal point, active-low
module seg_scan_display #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [2:0]  sel_i,
  input  logic        load_i,
  output logic        ack_o,
  output logic        frame_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int              PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    g = 7'h7F;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  logic [PW-1:0] presc_p0;
  logic [2:0]    idx_p0;
  logic [31:0]   disp_word_p0;
  logic [31:0]   pend_word_p0;
  logic          pend_vld_p0;
  logic          blink_on_p0;

  logic          tick;
  logic          boundary;
  logic          commit;
  logic [31:0]   commit_word;
  logic [3:0]    cur_nib;
  logic          cursor_hit;
  logic [7:0]    an_next;

  always_comb begin
    tick        = (presc_p0 == PRESC_MAX);
    boundary    = tick && (idx_p0 == 3'd7);
    // A load in the boundary cycle itself bypasses the pending register.
    commit      = boundary && (pend_vld_p0 || load_i);
    commit_word = load_i ? data_i : pend_word_p0;
    cur_nib     = disp_word_p0[{idx_p0, 2'b00} +: 4];
    cursor_hit  = (idx_p0 == sel_i);
    an_next     = ~(8'b0000_0001 << idx_p0);
    if (cursor_hit && !blink_on_p0) begin
      an_next = 8'hFF;
    end
  end

  // ---- stage p0: scan counters, handshake, display word ----
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_p0     <= '0;
      idx_p0       <= '0;
      disp_word_p0 <= '0;
      pend_vld_p0  <= 1'b0;
    end else begin
      presc_p0 <= tick ? '0 : presc_p0 + 1'b1;
      if (tick) begin
        idx_p0 <= idx_p0 + 3'd1;
      end
      if (commit) begin
        disp_word_p0 <= commit_word;
      end
      if (boundary) begin
        pend_vld_p0 <= 1'b0;
      end else if (load_i) begin
        pend_vld_p0 <= 1'b1;
      end
    end
  end

  // Pending data is plain storage; its validity lives in pend_vld_p0.
  always_ff @(posedge clk) begin
    if (load_i && !boundary) begin
      pend_word_p0 <= data_i;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int            BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BF_MAX = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_p0 <= '0;
      blink_on_p0  <= 1'b1;
    end else if (boundary) begin
      if (blink_cnt_p0 == BF_MAX) begin
        blink_cnt_p0 <= '0;
        blink_on_p0  <= ~blink_on_p0;
      end else begin
        blink_cnt_p0 <= blink_cnt_p0 + 1'b1;
      end
    end
  end
`else
  assign blink_on_p0 = 1'b1;
`endif

  // ---- stage p1: registered display outputs and pulses ----
  always_ff @(posedge clk) begin
    if (rst) begin
      an_o    <= 8'hFF;
      seg_o   <= 7'h7F;
      dp_o    <= 1'b1;
      ack_o   <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      an_o    <= an_next;
      seg_o   <= hex_glyph(cur_nib);
      dp_o    <= ~cursor_hit;
      ack_o   <= commit;
      frame_o <= boundary;
    end
  end

endmodule
